mem_ctrl: RTL and testbench

- Byte-serial memory controller inside the CPU core, between the instruction-fetch unit / load-store unit and the top-level RAM/IO bus of riscv_top.
- Arbitrates the two requesters and serialises multi-byte accesses onto the 8-bit bus (RAM read latency 1 cycle).
- Honours the UART io_buffer_full back-pressure.
- Supports the core-wide rdy_in pause and clear_in misprediction flush.

---
 rtl/mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the fetch unit,
// the load/store unit and the 8-bit RAM/IO bus.
// Ports:
//   clk_in, rst_in (async, active high), rdy_in (pause), clear_in (flush)
//   mem_din/mem_dout/mem_a/mem_wr : 8-bit bus, RAM read latency 1 cycle
//   io_buffer_full                : UART TX back-pressure
//   if_valid/if_addr -> if_done/if_data      : instruction fetch
//   ls_valid/ls_wr/ls_addr/ls_size/ls_wdata -> ls_done/ls_rdata : load/store
module mem_ctrl #(
  parameter int FETCH_BYTES = 4,
  parameter int ADDR_W      = 32,
  parameter int IO_HI       = 17
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_done,
  output logic [8*FETCH_BYTES-1:0] if_data,
  input  logic                     ls_valid,
  input  logic                     ls_wr,
  input  logic [ADDR_W-1:0]        ls_addr,
  input  logic [1:0]               ls_size,
  input  logic [31:0]              ls_wdata,
  output logic                     ls_done,
  output logic [31:0]              ls_rdata
);
  localparam int IFW = 8 * FETCH_BYTES;

  typedef enum logic [2:0] {
    IDLE, IF_RD, LS_RD, LS_WR, IO_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              if_done_q, if_done_d;
  logic              ls_done_q, ls_done_d;
  logic [IFW-1:0]    if_data_q, if_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              ls_io;
  logic [4:0]        ls_len;
  logic [4:0]        rd_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    mem_a_d    = mem_a_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    ls_io      = (ls_addr[IO_HI -: 2] == 2'b11);
    // cnt_q counts edges since accept; byte cnt-2 arrives on mem_din now
    rd_idx     = cnt_q - 5'd2;

    unique case (ls_size)
      2'b00:   ls_len = 5'd1;
      2'b01:   ls_len = 5'd2;
      default: ls_len = 5'd4;
    endcase

    unique case (state_q)
      IDLE: begin
        if (ls_valid) begin
          base_d  = ls_addr;
          wdata_d = ls_wdata;
          len_d   = ls_io ? 5'd1 : ls_len;
          cnt_d   = 5'd1;
          mem_a_d = ls_addr;
          if (ls_wr) begin
            if (ls_io && io_buffer_full) begin
              state_d = IO_WAIT;
              wr_d    = 1'b0;
            end else begin
              state_d = LS_WR;
              wr_d    = 1'b1;
              dout_d  = ls_wdata[7:0];
            end
          end else begin
            state_d    = LS_RD;
            ls_rdata_d = '0;
          end
        end else if (if_valid && !clear_in) begin
          base_d    = if_addr;
          len_d     = 5'(FETCH_BYTES);
          cnt_d     = 5'd1;
          mem_a_d   = if_addr;
          if_data_d = '0;
          state_d   = IF_RD;
        end
      end

      IF_RD, LS_RD: begin
        if (state_q == IF_RD && clear_in) begin
          // flush: drop the fetch, bus address left as is
          state_d = IDLE;
        end else begin
          if (cnt_q < len_q)
            mem_a_d = base_q + ADDR_W'(cnt_q);
          if (cnt_q >= 5'd2) begin
            if (state_q == IF_RD) begin
              for (int b = 0; b < FETCH_BYTES; b++)
                if (rd_idx == 5'(b))
                  if_data_d[8*b +: 8] = mem_din;
            end else begin
              for (int b = 0; b < 4; b++)
                if (rd_idx == 5'(b))
                  ls_rdata_d[8*b +: 8] = mem_din;
            end
          end
          if (cnt_q == len_q + 5'd1) begin
            state_d = IDLE;
            if (state_q == IF_RD) if_done_d = 1'b1;
            else                  ls_done_d = 1'b1;
          end
          cnt_d = cnt_q + 5'd1;
        end
      end

      LS_WR: begin
        if (cnt_q == len_q) begin
          wr_d      = 1'b0;
          ls_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_a_d = base_q + ADDR_W'(cnt_q);
          dout_d  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d   = cnt_q + 5'd1;
        end
      end

      IO_WAIT: begin
        if (!io_buffer_full) begin
          state_d = LS_WR;
          wr_d    = 1'b1;
          mem_a_d = base_q;
          dout_d  = wdata_q[7:0];
          cnt_d   = 5'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      mem_a_q    <= mem_a_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // a held write byte must not hit the bus while paused
  assign mem_wr   = wr_q & rdy_in;
  assign mem_a    = mem_a_q;
  assign mem_dout = dout_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed test of mem_ctrl
// fetch, load, store, IO stall, flush, pause, reset
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_valid, ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  rom [0:4095];
  logic [31:0] wa  [0:63];
  logic [7:0]  wd  [0:63];
  int wr_n  = 0;
  int io_n  = 0;
  int ifd_n = 0;
  int w0, n0;

  always #5 clk = ~clk;

  mem_ctrl #(.FETCH_BYTES(4), .ADDR_W(32), .IO_HI(17)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_full),
    .if_valid(if_valid), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr),
    .ls_size(ls_size), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  // bus model: 1-cycle read latency, write log
  always @(posedge clk) begin
    mem_din <= rom[mem_a[11:0]];
    if (mem_wr) begin
      wa[wr_n % 64] <= mem_a;
      wd[wr_n % 64] <= mem_dout;
      wr_n <= wr_n + 1;
      if (mem_a[17:16] == 2'b11) io_n <= io_n + 1;
    end
    if (if_done) ifd_n <= ifd_n + 1;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sw, pw;
    sw = 32'hDEADBEEF;
    pw = 32'hCAFEF00D;
    rst = 1; rdy = 1; clr = 0; io_full = 0;
    if_valid = 0; if_addr = 0;
    ls_valid = 0; ls_wr = 0; ls_addr = 0;
    ls_size = 0; ls_wdata = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h100] = 8'h13; rom[12'h101] = 8'h05;
    rom[12'h200] = 8'h11; rom[12'h201] = 8'h22;
    rom[12'h202] = 8'h33; rom[12'h203] = 8'h44;
    rom[12'h204] = 8'hFF;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_a", mem_a, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_dout", mem_dout, 0);
    chk("rst_ifd", if_done, 0);
    chk("rst_lsd", ls_done, 0);
    chk("rst_ifdat", if_data, 0);
    chk("rst_lsdat", ls_rdata, 0);
    rst = 0;

    // reset mid-read
    @(negedge clk);
    if_valid = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("mid_acc", mem_a, 32'h100);
    rst = 1;
    #1;
    chk("mid_a", mem_a, 0);
    chk("mid_ifd", if_done, 0);
    if_valid = 0;
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    chk("mid_nodone", ifd_n, 0);
    chk("mid_idle_a", mem_a, 0);

    // plain fetch
    if_valid = 1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("f_a", mem_a, 32'h100 + k);
      chk("f_wr", mem_wr, 0);
    end
    @(negedge clk);
    chk("f_early", if_done, 0);
    @(negedge clk);
    chk("f_done", if_done, 1);
    chk("f_data", if_data, 32'h00000513);
    if_valid = 0;
    @(negedge clk);
    chk("f_pulse", if_done, 0);

    // arbitration: load beats fetch
    ls_valid = 1; ls_wr = 0; ls_addr = 32'h204; ls_size = 0;
    if_valid = 1; if_addr = 32'h200;
    @(negedge clk);
    chk("arb_a", mem_a, 32'h204);
    @(negedge clk);
    chk("arb_early", ls_done, 0);
    @(negedge clk);
    chk("arb_done", ls_done, 1);
    chk("arb_rd", ls_rdata, 32'h000000FF);
    chk("arb_noif", if_done, 0);
    ls_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arb_fa", mem_a, 32'h200 + k);
    end
    @(negedge clk);
    chk("arb_fearly", if_done, 0);
    @(negedge clk);
    chk("arb_fdone", if_done, 1);
    chk("arb_fdata", if_data, 32'h44332211);
    if_valid = 0;

    // store word
    @(negedge clk);
    w0 = wr_n;
    ls_valid = 1; ls_wr = 1; ls_addr = 32'h300;
    ls_size = 2'b10; ls_wdata = sw;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("st_wr", mem_wr, 1);
      chk("st_a", mem_a, 32'h300 + k);
      chk("st_d", mem_dout, (sw >> (8 * k)) & 32'hFF);
    end
    @(negedge clk);
    chk("st_wr0", mem_wr, 0);
    chk("st_done", ls_done, 1);
    ls_valid = 0;
    @(negedge clk);
    chk("st_cnt", wr_n - w0, 4);

    // IO write under back-pressure
    w0 = wr_n;
    ls_valid = 1; ls_wr = 1; ls_addr = 32'h30000;
    ls_size = 2'b10; ls_wdata = 32'h12345641; io_full = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("io_stall", mem_wr, 0);
    end
    io_full = 0;
    @(negedge clk);
    chk("io_wr", mem_wr, 1);
    chk("io_a", mem_a, 32'h30000);
    chk("io_d", mem_dout, 8'h41);
    @(negedge clk);
    chk("io_wr0", mem_wr, 0);
    chk("io_done", ls_done, 1);
    ls_valid = 0;
    @(negedge clk);
    chk("io_cnt", wr_n - w0, 1);
    chk("io_n", io_n, 1);

    // flush during 3rd cycle of a fetch
    n0 = ifd_n;
    if_valid = 1; if_addr = 32'h100;
    @(negedge clk);
    chk("cl_a", mem_a, 32'h100);
    @(negedge clk);
    @(negedge clk);
    clr = 1; if_valid = 0;
    @(negedge clk);
    chk("cl_hold", mem_a, 32'h102);
    chk("cl_wr", mem_wr, 0);
    chk("cl_nod", if_done, 0);
    clr = 0; if_valid = 1; if_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cl_na", mem_a, 32'h200 + k);
    end
    @(negedge clk);
    chk("cl_early", if_done, 0);
    @(negedge clk);
    chk("cl_done", if_done, 1);
    chk("cl_data", if_data, 32'h44332211);
    chk("cl_nopulse", ifd_n - n0, 0);
    if_valid = 0;

    // pause in the middle of a store
    @(negedge clk);
    w0 = wr_n;
    ls_valid = 1; ls_wr = 1; ls_addr = 32'h310;
    ls_size = 2'b10; ls_wdata = pw;
    @(negedge clk);
    chk("p_wr0", mem_wr, 1);
    chk("p_a0", mem_a, 32'h310);
    @(negedge clk);
    rdy = 0;
    #1;
    chk("p_off", mem_wr, 0);
    chk("p_a1", mem_a, 32'h311);
    @(negedge clk);
    chk("p_hold_a", mem_a, 32'h311);
    chk("p_hold_wr", mem_wr, 0);
    @(negedge clk);
    rdy = 1;
    #1;
    chk("p_on", mem_wr, 1);
    chk("p_d1", mem_dout, 8'hF0);
    @(negedge clk);
    chk("p_a2", mem_a, 32'h312);
    @(negedge clk);
    chk("p_a3", mem_a, 32'h313);
    @(negedge clk);
    chk("p_done", ls_done, 1);
    ls_valid = 0;
    @(negedge clk);
    chk("p_cnt", wr_n - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("p_loga", wa[(w0 + i) % 64], 32'h310 + i);
      chk("p_logd", wd[(w0 + i) % 64], (pw >> (8 * i)) & 32'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
